// File: rtl/fa_seq_pkg.sv
// Shared types, run lengths and full-adder reference functions for the vector sequencer.
package fa_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    MODE_TT   = 1'b0,
    MODE_WALK = 1'b1
  } mode_e;

  localparam int unsigned TT_LEN   = 8;
  localparam int unsigned WALK_LEN = 63;

  // Vector bit order is {a, b, c}.
  function automatic logic exp_sum(input logic [2:0] v);
    return v[2] ^ v[1] ^ v[0];
  endfunction

  function automatic logic exp_carry(input logic [2:0] v);
    return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
  endfunction

endpackage

// File: rtl/transition_walker.sv
// Generates the 63-step walk: for each base i, emit i, then j,i for every j > i,
// so every ordered pair between distinct vectors is traversed in both directions.
module transition_walker (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init,
  input  logic       advance,
  output logic [2:0] vec_o,
  output logic       last_o
);

  logic [2:0] base_q, base_d;
  logic [3:0] part_q, part_d;   // 8 means every partner of this base is used up
  logic       phase_q, phase_d; // 1: partner is on the output

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q  <= 3'd0;
      part_q  <= 4'd1;
      phase_q <= 1'b0;
    end else begin
      base_q  <= base_d;
      part_q  <= part_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    base_d  = base_q;
    part_d  = part_q;
    phase_d = phase_q;
    if (init) begin
      base_d  = 3'd0;
      part_d  = 4'd1;
      phase_d = 1'b0;
    end else if (advance) begin
      if (phase_q) begin
        part_d  = part_q + 4'd1;
        phase_d = 1'b0;
      end else if (part_q == 4'd8) begin
        base_d  = base_q + 3'd1;
        part_d  = {1'b0, base_q} + 4'd2;
        phase_d = 1'b0;
      end else begin
        phase_d = 1'b1;
      end
    end
  end

  assign vec_o  = phase_q ? part_q[2:0] : base_q;
  assign last_o = (base_q == 3'd6) && !phase_q && (part_q == 4'd8);

endmodule

// File: rtl/fa_vector_sequencer.sv
// Drives a full-adder cell through truth-table or transition-walk vectors, holding each
// for HOLD_CYCLES and counting sum/carry mismatches sampled on the last hold cycle.
module fa_vector_sequencer
  import fa_seq_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       y0,
  input  logic       y1,
  output logic       busy,
  output logic       done,
  output logic [5:0] vec_index,
  output logic [6:0] err_count,
  output logic [1:0] dbg_state_o
);

  // Handshake: start is a request taken only while IDLE (busy and done low); once taken,
  // busy stays high for the whole run and done pulses one cycle after the final sample.
  localparam int unsigned   HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  state_e        state_q, state_d;
  mode_e         mode_q, mode_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [5:0]    idx_q, idx_d;
  logic [6:0]    err_q, err_d;

  logic          start_acc;
  logic          sample;
  logic          last_vec;
  logic          step;
  logic [2:0]    walk_vec;
  logic          walk_last;
  logic [2:0]    cur_vec;

  assign start_acc = (state_q == IDLE) && start;
  assign sample    = (state_q == HOLD) && (hold_q == '0);
  assign cur_vec   = (mode_q == MODE_WALK) ? walk_vec : idx_q[2:0];
  assign last_vec  = (mode_q == MODE_WALK) ? walk_last : (idx_q == 6'(TT_LEN - 1));
  assign step      = sample && !last_vec;

  transition_walker u_walker (
    .clk    (clk),
    .rst_n  (rst_n),
    .init   (start_acc),
    .advance(step && (mode_q == MODE_WALK)),
    .vec_o  (walk_vec),
    .last_o (walk_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = HOLD;
      HOLD:    if (sample && last_vec) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    {a, b, c} = 3'b000;
    case (state_q)
      HOLD: begin
        busy      = 1'b1;
        {a, b, c} = cur_vec;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_TT;
      hold_q <= '0;
      idx_q  <= 6'd0;
      err_q  <= 7'd0;
    end else begin
      mode_q <= mode_d;
      hold_q <= hold_d;
      idx_q  <= idx_d;
      err_q  <= err_d;
    end
  end

  // The cell is combinational, so y0/y1 already reflect cur_vec on its last hold cycle.
  always_comb begin
    mode_d = mode_q;
    hold_d = hold_q;
    idx_d  = idx_q;
    err_d  = err_q;
    if (start_acc) begin
      mode_d = mode_e'(mode);
      hold_d = HOLD_LOAD;
      idx_d  = 6'd0;
      err_d  = 7'd0;
    end else if (state_q == HOLD) begin
      if (hold_q == '0) begin
        err_d = err_q + 7'(y0 != exp_sum(cur_vec)) + 7'(y1 != exp_carry(cur_vec));
        if (!last_vec) begin
          idx_d  = idx_q + 6'd1;
          hold_d = HOLD_LOAD;
        end
      end else begin
        hold_d = hold_q - HW'(1);
      end
    end
  end

  assign vec_index   = idx_q;
  assign err_count   = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fa_vector_sequencer.sv
// Scoreboard bench: three sequencers (hold 4, 1, 2) each feeding a behavioural full-adder
// cell with selectable faults; expected vectors and error counts are queued per run.
module tb_fa_vector_sequencer;

  // Hand-written walk order: base i, then j,i for every j > i.
  localparam int WALK_SEQ [0:62] = '{
    0, 1, 0, 2, 0, 3, 0, 4, 0, 5, 0, 6, 0, 7, 0,
    1, 2, 1, 3, 1, 4, 1, 5, 1, 6, 1, 7, 1,
    2, 3, 2, 4, 2, 5, 2, 6, 2, 7, 2,
    3, 4, 3, 5, 3, 6, 3, 7, 3,
    4, 5, 4, 6, 4, 7, 4,
    5, 6, 5, 7, 5,
    6, 7, 6
  };

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs and cell models ----------------
  logic       start_v [3];
  logic       mode_v  [3];
  int         fault_v [3];  // 0 good cell, 1 carry stuck at 0, 2 both outputs inverted
  logic       a_w [3];
  logic       b_w [3];
  logic       c_w [3];
  logic       y0_w [3];
  logic       y1_w [3];
  logic       busy_w [3];
  logic       done_w [3];
  logic [5:0] idx_w [3];
  logic [6:0] err_w [3];
  logic [1:0] st_w [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned HG = (g == 0) ? 4 : (g == 1) ? 1 : 2;
    logic maj;
    logic par;
    assign par = a_w[g] ^ b_w[g] ^ c_w[g];
    assign maj = (a_w[g] & b_w[g]) | (a_w[g] & c_w[g]) | (b_w[g] & c_w[g]);
    assign y0_w[g] = (fault_v[g] == 2) ? ~par : par;
    assign y1_w[g] = (fault_v[g] == 1) ? 1'b0 : (fault_v[g] == 2) ? ~maj : maj;

    fa_vector_sequencer #(.HOLD_CYCLES(HG)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start_v[g]),
      .mode       (mode_v[g]),
      .a          (a_w[g]),
      .b          (b_w[g]),
      .c          (c_w[g]),
      .y0         (y0_w[g]),
      .y1         (y1_w[g]),
      .busy       (busy_w[g]),
      .done       (done_w[g]),
      .vec_index  (idx_w[g]),
      .err_count  (err_w[g]),
      .dbg_state_o(st_w[g])
    );
  end

  // Outputs of the instance currently under test.
  int         sel = 0;
  logic       m_busy;
  logic       m_done;
  logic [2:0] m_abc;
  logic [5:0] m_idx;
  logic [6:0] m_err;
  logic [1:0] m_state;
  always_comb begin
    m_busy  = busy_w[sel];
    m_done  = done_w[sel];
    m_abc   = {a_w[sel], b_w[sel], c_w[sel]};
    m_idx   = idx_w[sel];
    m_err   = err_w[sel];
    m_state = st_w[sel];
  end

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];      // {vec_index, a, b, c} for every busy cycle
  logic [6:0] exp_err_q[$];  // err_count expected at done
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int n_runs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int hold_of(input int s);
    return (s == 0) ? 4 : (s == 1) ? 1 : 2;
  endfunction

  task automatic push_run(input int s, input bit md);
    int h = hold_of(s);
    int n = md ? 63 : 8;
    int v;
    for (int k = 0; k < n; k++) begin
      v = md ? WALK_SEQ[k] : k;
      for (int r = 0; r < h; r++) exp_q.push_back({6'(k), 3'(v)});
    end
  endtask

  // Monitor: pops one expected vector per busy cycle, one err_count per done pulse.
  initial begin : monitor
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (m_busy) begin
          if (exp_q.size() == 0) begin
            check("extra_busy_cycle", 32'(m_busy), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("vec_idx_abc", {m_idx, m_abc}, e);
          end
        end
        if (m_done) begin
          done_cnt++;
          if (exp_err_q.size() == 0) begin
            check("unexpected_done", 32'(m_done), 32'd0);
          end else begin
            check("err_count", m_err, exp_err_q.pop_front());
            check("vectors_left_at_done", exp_q.size(), 32'd0);
            check("abc_in_done", m_abc, 32'd0);
            check("busy_in_done", m_busy, 32'd0);
          end
        end
      end
    end
  end

  // ---------------- driver tasks (entered and left just after a negedge) ----------------
  task automatic run(input int s, input bit md, input int fm, input logic [6:0] exp_err,
                     input bit disturb);
    int n_vec = md ? 63 : 8;
    int h = hold_of(s);
    int cyc;
    int done_at = 0;
    int done_before;
    sel = s;
    fault_v[s] = fm;
    push_run(s, md);
    exp_err_q.push_back(exp_err);
    n_runs++;
    done_before = done_cnt;
    mode_v[s] = md;
    start_v[s] = 1'b1;
    @(negedge clk);
    start_v[s] = 1'b0;
    cyc = 1;
    check("busy_rise", m_busy, 32'd1);
    while (done_at == 0 && cyc < n_vec * h + 20) begin
      if (m_done) begin
        done_at = cyc;
      end else begin
        if (disturb) begin
          start_v[s] = (cyc % 3 == 0);
          mode_v[s]  = ~mode_v[s];
        end
        @(negedge clk);
        cyc++;
      end
    end
    start_v[s] = 1'b0;
    check("done_cycle", done_at, n_vec * h + 1);
    if (disturb) begin
      start_v[s] = 1'b1;  // offered during DONE: must be ignored
      @(negedge clk);
      start_v[s] = 1'b0;
      check("done_pulse_width", m_done, 32'd0);
      @(negedge clk);
      check("start_in_done_ignored", m_busy, 32'd0);
      check("one_done_per_run", done_cnt - done_before, 32'd1);
    end else begin
      @(negedge clk);
      check("done_pulse_width", m_done, 32'd0);
      check("idle_after_done", m_state, 32'd0);
    end
  endtask

  task automatic reset_mid_run();
    int cyc = 0;
    sel = 0;
    fault_v[0] = 1;
    push_run(0, 1'b0);
    mode_v[0] = 1'b0;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    while (m_idx != 6'd5 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("reached_vec5", m_idx, 32'd5);
    check("err_before_reset", m_err, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_abc", m_abc, 32'd0);
    check("rst_busy", m_busy, 32'd0);
    check("rst_done", m_done, 32'd0);
    check("rst_err", m_err, 32'd0);
    check("rst_idx", m_idx, 32'd0);
    check("rst_state", m_state, 32'd0);
    exp_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      mode_v[i]  = 1'b0;
      fault_v[i] = 0;
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("reset_abc", m_abc, 32'd0);
    check("reset_busy", m_busy, 32'd0);
    check("reset_done", m_done, 32'd0);
    check("reset_idx", m_idx, 32'd0);
    check("reset_err", m_err, 32'd0);
    check("reset_state", m_state, 32'd0);

    run(0, 1'b0, 0, 7'd0,   1'b0);  // truth table, H=4, good cell
    run(0, 1'b0, 1, 7'd4,   1'b0);  // restart at first IDLE cycle, carry stuck at 0
    run(1, 1'b1, 0, 7'd0,   1'b0);  // walk, H=1, good cell
    run(2, 1'b1, 2, 7'd126, 1'b0);  // walk, H=2, both outputs inverted
    reset_mid_run();
    run(0, 1'b0, 0, 7'd0,   1'b1);  // full run after reset, start/mode disturbed
    run(1, 1'b1, 1, 7'd31,  1'b1);  // walk, H=1, carry stuck: 31 vectors have carry=1

    check("done_pulses_total", done_cnt, n_runs);
    check("scoreboard_drained", exp_q.size() + exp_err_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
